// File: rtl/demux_burst_scheduler.sv
// Burst scheduler: steers fixed-length bursts of upstream words onto one of two
// downstream channels through a single one-word holding register.
module demux_burst_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  Clock_In,
    input  logic                  Reset_n_In,
    input  logic                  Enable_In,
    input  logic [1:0]            Mode_In,
    input  logic [DATA_WIDTH-1:0] Data_In,
    input  logic                  Valid_In,
    output logic                  Ready_Out,
    output logic [DATA_WIDTH-1:0] Data_0_Out,
    output logic [DATA_WIDTH-1:0] Data_1_Out,
    output logic                  Valid_0_Out,
    output logic                  Valid_1_Out,
    input  logic                  Ready_0_In,
    input  logic                  Ready_1_In,
    output logic                  Select_Out,
    output logic                  Burst_Done_Out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARB   = 2'b01,
        ST_XFER  = 2'b10,
        ST_DRAIN = 2'b11
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

    state_t                r_state;
    logic                  r_sel;
    logic                  r_last;
    logic [7:0]            r_cnt;
    logic                  r_hold_valid;
    logic [DATA_WIDTH-1:0] r_hold_data;

    logic w_sel_rdy;
    logic w_xfer;
    logic w_accept;
    logic w_done;
    logic w_arb_ok;
    logic w_arb_ch;

    assign w_sel_rdy = r_sel ? Ready_1_In : Ready_0_In;
    assign w_xfer    = r_hold_valid & w_sel_rdy;
    assign Ready_Out = (r_state == ST_XFER) & Enable_In & (~r_hold_valid | w_sel_rdy);
    assign w_accept  = Valid_In & Ready_Out;
    assign w_done    = (r_state == ST_DRAIN) & (~r_hold_valid | w_sel_rdy);

    assign Select_Out     = r_sel;
    assign Burst_Done_Out = w_done;
    assign Valid_0_Out    = r_hold_valid & ~r_sel;
    assign Valid_1_Out    = r_hold_valid & r_sel;
    assign Data_0_Out     = r_sel ? {DATA_WIDTH{1'b0}} : r_hold_data;
    assign Data_1_Out     = r_sel ? r_hold_data : {DATA_WIDTH{1'b0}};

    // Channel choice for the next burst; Mode_In is only looked at here, in ARB.
    always_comb begin
        w_arb_ok = 1'b1;
        w_arb_ch = 1'b0;
        case (Mode_In)
            2'b00: w_arb_ch = 1'b0;
            2'b01: w_arb_ch = 1'b1;
            2'b10: w_arb_ch = ~r_last;
            2'b11: begin
                if (Ready_0_In && Ready_1_In) begin
                    w_arb_ch = ~r_last;
                end else if (Ready_0_In) begin
                    w_arb_ch = 1'b0;
                end else if (Ready_1_In) begin
                    w_arb_ch = 1'b1;
                end else begin
                    w_arb_ok = 1'b0;
                end
            end
            default: w_arb_ok = 1'b0;
        endcase
    end

    // Holding register, burst counter and control state.
    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            r_state      <= ST_IDLE;
            r_sel        <= 1'b0;
            r_last       <= 1'b1;
            r_cnt        <= 8'd0;
            r_hold_valid <= 1'b0;
            r_hold_data  <= {DATA_WIDTH{1'b0}};
        end else begin
            // A load wins over an unload so back-to-back words stream at full rate.
            if (w_accept) begin
                r_hold_data  <= Data_In;
                r_hold_valid <= 1'b1;
            end else if (w_xfer) begin
                r_hold_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (Enable_In) begin
                        r_state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (!Enable_In) begin
                        r_state <= ST_IDLE;
                    end else if (w_arb_ok) begin
                        r_sel   <= w_arb_ch;
                        r_cnt   <= 8'd0;
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == LAST_IDX) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_done) begin
                        r_last  <= r_sel;
                        r_state <= ST_ARB;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_burst_scheduler.sv
// Directed bench for demux_burst_scheduler (DATA_WIDTH=8, BURST_LEN=4).
module tb_demux_burst_scheduler;

    logic       Clock_In = 1'b0;
    logic       Reset_n_In = 1'b0;
    logic       Enable_In = 1'b0;
    logic [1:0] Mode_In = 2'b10;
    logic [7:0] Data_In = 8'h00;
    logic       Valid_In = 1'b0;
    logic       Ready_Out;
    logic [7:0] Data_0_Out, Data_1_Out;
    logic       Valid_0_Out, Valid_1_Out;
    logic       Ready_0_In = 1'b1;
    logic       Ready_1_In = 1'b1;
    logic       Select_Out;
    logic       Burst_Done_Out;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] e0 [20] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04,
                            8'h21, 8'h22, 8'h23, 8'h24, 8'h41, 8'h42, 8'h43, 8'h44,
                            8'h51, 8'h52, 8'h53, 8'h54};
    logic [7:0] e1 [10] = '{8'h05, 8'h06, 8'h07, 8'h08, 8'h11, 8'h12, 8'h13, 8'h14,
                            8'h31, 8'h61};

    demux_burst_scheduler #(.DATA_WIDTH(8), .BURST_LEN(4)) dut (
        .Clock_In       (Clock_In),
        .Reset_n_In     (Reset_n_In),
        .Enable_In      (Enable_In),
        .Mode_In        (Mode_In),
        .Data_In        (Data_In),
        .Valid_In       (Valid_In),
        .Ready_Out      (Ready_Out),
        .Data_0_Out     (Data_0_Out),
        .Data_1_Out     (Data_1_Out),
        .Valid_0_Out    (Valid_0_Out),
        .Valid_1_Out    (Valid_1_Out),
        .Ready_0_In     (Ready_0_In),
        .Ready_1_In     (Ready_1_In),
        .Select_Out     (Select_Out),
        .Burst_Done_Out (Burst_Done_Out)
    );

    always #10 Clock_In = ~Clock_In;

    // Record every downstream transfer and completion pulse, mid-cycle.
    always @(negedge Clock_In) begin
        if (Reset_n_In) begin
            if (Valid_0_Out && Ready_0_In) q0.push_back(Data_0_Out);
            if (Valid_1_Out && Ready_1_In) q1.push_back(Data_1_Out);
            if (Burst_Done_Out) n_done++;
        end
    end

    task automatic step();
        @(posedge Clock_In);
        #2;
    endtask

    task automatic ex(input string tag, input logic rdy, input logic done, input logic sel,
                      input logic v0, input logic v1, input logic [7:0] d0, input logic [7:0] d1);
        logic [20:0] obs;
        logic [20:0] want;
        #1;
        obs  = {Ready_Out, Burst_Done_Out, Select_Out, Valid_0_Out, Valid_1_Out, Data_0_Out, Data_1_Out};
        want = {rdy, done, sel, v0, v1, d0, d1};
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed={rdy,done,sel,v0,v1,d0,d1}=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic chk(input string tag, input int obs, input int want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    initial begin
        // reset state
        #5;  ex("rst0", 0, 0, 0, 0, 0, 8'h00, 8'h00);
        step(); ex("rst1", 0, 0, 0, 0, 0, 8'h00, 8'h00);
        #3; Reset_n_In = 1'b1;

        // round-robin, two back-to-back bursts
        Enable_In = 1'b1; Valid_In = 1'b1; Data_In = 8'h01;
        ex("t1idle", 0, 0, 0, 0, 0, 8'h00, 8'h00);
        step(); ex("t1arb", 0, 0, 0, 0, 0, 8'h00, 8'h00);
        step(); ex("t1x0", 1, 0, 0, 0, 0, 8'h00, 8'h00);
        step(); Data_In = 8'h02; ex("t1w1", 1, 0, 0, 1, 0, 8'h01, 8'h00);
        step(); Data_In = 8'h03; ex("t1w2", 1, 0, 0, 1, 0, 8'h02, 8'h00);
        step(); Data_In = 8'h04; ex("t1w3", 1, 0, 0, 1, 0, 8'h03, 8'h00);
        step(); Data_In = 8'h05; ex("t1dr0", 0, 1, 0, 1, 0, 8'h04, 8'h00);
        step(); ex("t1arb2", 0, 0, 0, 0, 0, 8'h04, 8'h00);
        step(); ex("t1x1", 1, 0, 1, 0, 0, 8'h00, 8'h04);
        step(); Data_In = 8'h06; ex("t1w5", 1, 0, 1, 0, 1, 8'h00, 8'h05);
        step(); Data_In = 8'h07; ex("t1w6", 1, 0, 1, 0, 1, 8'h00, 8'h06);
        step(); Data_In = 8'h08; ex("t1w7", 1, 0, 1, 0, 1, 8'h00, 8'h07);
        step(); Valid_In = 1'b0; Enable_In = 1'b0; ex("t1dr1", 0, 1, 1, 0, 1, 8'h00, 8'h08);
        step(); ex("t1arb3", 0, 0, 1, 0, 0, 8'h00, 8'h08);
        step(); ex("t1idle2", 0, 0, 1, 0, 0, 8'h00, 8'h08);

        // fixed ch0 with downstream stall of 5 cycles
        Mode_In = 2'b00; Enable_In = 1'b1; Valid_In = 1'b1; Data_In = 8'h01;
        ex("t2idle", 0, 0, 1, 0, 0, 8'h00, 8'h08);
        step(); ex("t2arb", 0, 0, 1, 0, 0, 8'h00, 8'h08);
        step(); ex("t2x", 1, 0, 0, 0, 0, 8'h08, 8'h00);
        step(); Data_In = 8'h02; Ready_0_In = 1'b0; ex("t2st1", 0, 0, 0, 1, 0, 8'h01, 8'h00);
        step(); ex("t2st2", 0, 0, 0, 1, 0, 8'h01, 8'h00);
        step(); ex("t2st3", 0, 0, 0, 1, 0, 8'h01, 8'h00);
        step(); ex("t2st4", 0, 0, 0, 1, 0, 8'h01, 8'h00);
        step(); Ready_0_In = 1'b1; ex("t2st5", 1, 0, 0, 1, 0, 8'h01, 8'h00);
        step(); Data_In = 8'h03; ex("t2w2", 1, 0, 0, 1, 0, 8'h02, 8'h00);
        step(); Data_In = 8'h04; ex("t2w3", 1, 0, 0, 1, 0, 8'h03, 8'h00);
        step(); Valid_In = 1'b0; Mode_In = 2'b11; ex("t2dr", 0, 1, 0, 1, 0, 8'h04, 8'h00);

        // ready-priority: only ch1 ready, stalled drain, then neither ready, then both
        step(); Ready_0_In = 1'b0; Valid_In = 1'b1; Data_In = 8'h11; ex("t3arb", 0, 0, 0, 0, 0, 8'h04, 8'h00);
        step(); ex("t3sel1", 1, 0, 1, 0, 0, 8'h00, 8'h04);
        step(); Data_In = 8'h12; ex("t3w1", 1, 0, 1, 0, 1, 8'h00, 8'h11);
        step(); Data_In = 8'h13; ex("t3w2", 1, 0, 1, 0, 1, 8'h00, 8'h12);
        step(); Data_In = 8'h14; ex("t3w3", 1, 0, 1, 0, 1, 8'h00, 8'h13);
        step(); Valid_In = 1'b0; Ready_1_In = 1'b0; ex("t3drst", 0, 0, 1, 0, 1, 8'h00, 8'h14);
        step(); ex("t3drst2", 0, 0, 1, 0, 1, 8'h00, 8'h14);
        Ready_1_In = 1'b1; ex("t3dr", 0, 1, 1, 0, 1, 8'h00, 8'h14);
        step(); Ready_1_In = 1'b0; ex("t3arb2", 0, 0, 1, 0, 0, 8'h00, 8'h14);
        step(); ex("t3hold1", 0, 0, 1, 0, 0, 8'h00, 8'h14);
        step(); Ready_0_In = 1'b1; Ready_1_In = 1'b1; ex("t3hold2", 0, 0, 1, 0, 0, 8'h00, 8'h14);

        // both ready picks inverse of last (ch0); enable drop after 2 words
        step(); Valid_In = 1'b1; Data_In = 8'h21; ex("t4sel0", 1, 0, 0, 0, 0, 8'h14, 8'h00);
        step(); Data_In = 8'h22; ex("t4w1", 1, 0, 0, 1, 0, 8'h21, 8'h00);
        step(); Data_In = 8'h23; Enable_In = 1'b0; ex("t4off", 0, 0, 0, 1, 0, 8'h22, 8'h00);
        step(); ex("t4drain", 0, 0, 0, 0, 0, 8'h22, 8'h00);
        step(); Enable_In = 1'b1; ex("t4on", 1, 0, 0, 0, 0, 8'h22, 8'h00);
        step(); Data_In = 8'h24; ex("t4w3", 1, 0, 0, 1, 0, 8'h23, 8'h00);
        step(); Valid_In = 1'b0; Mode_In = 2'b10; ex("t4dr", 0, 1, 0, 1, 0, 8'h24, 8'h00);

        // round-robin burst on ch1 interrupted by asynchronous reset
        step(); Valid_In = 1'b1; Data_In = 8'h31; ex("t5arb", 0, 0, 0, 0, 0, 8'h24, 8'h00);
        step(); ex("t5sel1", 1, 0, 1, 0, 0, 8'h00, 8'h24);
        step(); Data_In = 8'h32; ex("t5w1", 1, 0, 1, 0, 1, 8'h00, 8'h31);
        step(); ex("t5w2", 1, 0, 1, 0, 1, 8'h00, 8'h32);
        #2; Reset_n_In = 1'b0;
        ex("t5rst", 0, 0, 0, 0, 0, 8'h00, 8'h00);
        Data_In = 8'h41;
        step(); ex("t5rsth", 0, 0, 0, 0, 0, 8'h00, 8'h00);
        #3; Reset_n_In = 1'b1;

        // first round-robin burst after reset goes to ch0; mode changes mid-burst
        step(); ex("t6arb", 0, 0, 0, 0, 0, 8'h00, 8'h00);
        step(); ex("t6sel0", 1, 0, 0, 0, 0, 8'h00, 8'h00);
        step(); Data_In = 8'h42; Mode_In = 2'b00; ex("t6w1", 1, 0, 0, 1, 0, 8'h41, 8'h00);
        step(); Data_In = 8'h43; ex("t6w2", 1, 0, 0, 1, 0, 8'h42, 8'h00);
        step(); Data_In = 8'h44; ex("t6w3", 1, 0, 0, 1, 0, 8'h43, 8'h00);
        step(); Data_In = 8'h51; ex("t6dr", 0, 1, 0, 1, 0, 8'h44, 8'h00);
        step(); ex("t7arb", 0, 0, 0, 0, 0, 8'h44, 8'h00);
        step(); ex("t7sel0", 1, 0, 0, 0, 0, 8'h44, 8'h00);
        step(); Data_In = 8'h52; Mode_In = 2'b01; ex("t7w1", 1, 0, 0, 1, 0, 8'h51, 8'h00);
        step(); Data_In = 8'h53; ex("t7w2", 1, 0, 0, 1, 0, 8'h52, 8'h00);
        step(); Data_In = 8'h54; ex("t7w3", 1, 0, 0, 1, 0, 8'h53, 8'h00);
        step(); Data_In = 8'h61; ex("t7dr", 0, 1, 0, 1, 0, 8'h54, 8'h00);
        step(); ex("t8arb", 0, 0, 0, 0, 0, 8'h54, 8'h00);
        step(); ex("t8sel1", 1, 0, 1, 0, 0, 8'h00, 8'h54);
        step(); Valid_In = 1'b0; Enable_In = 1'b0; ex("t8w1", 0, 0, 1, 0, 1, 8'h00, 8'h61);
        step(); ex("t8out", 0, 0, 1, 0, 0, 8'h00, 8'h61);
        step();

        // end-to-end: nothing lost, nothing duplicated, completion count
        chk("q0len", q0.size(), 20);
        chk("q1len", q1.size(), 10);
        for (int i = 0; i < 20; i++) begin
            if (i < q0.size()) chk($sformatf("q0[%0d]", i), int'(q0[i]), int'(e0[i]));
        end
        for (int i = 0; i < 10; i++) begin
            if (i < q1.size()) chk($sformatf("q1[%0d]", i), int'(q1[i]), int'(e1[i]));
        end
        chk("ndone", n_done, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demux_burst_scheduler.md
DEMUX_BURST_SCHEDULER -- requirements
Module: demux_burst_scheduler

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, word width; BURST_LEN, default 4, words per burst (range 1..255).
REQ-002 Clock_In  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Reset_n_In  input  1  reset, asynchronous and active-low.
REQ-004 Enable_In  input  1  high permits new bursts and input acceptance.
REQ-005 Mode_In  input  2  channel policy: 00 fixed ch0, 01 fixed ch1, 10 round-robin, 11 ready-priority.
REQ-006 Data_In  input  DATA_WIDTH  upstream word.
REQ-007 Valid_In  input  1  upstream word valid.
REQ-008 Ready_Out  output  1  block accepts Data_In this cycle.
REQ-009 Data_0_Out, Data_1_Out  output  DATA_WIDTH each  per-channel data.
REQ-010 Valid_0_Out, Valid_1_Out  output  1 each  per-channel valid.
REQ-011 Ready_0_In, Ready_1_In  input  1 each  per-channel downstream ready.
REQ-012 Select_Out  output  1  channel owning the current burst.
REQ-013 Burst_Done_Out  output  1  one-cycle pulse at burst completion.

Function
REQ-014 States SHALL be IDLE, ARB, XFER and DRAIN.
REQ-015 IDLE->ARB SHALL occur when Enable_In=1; ARB->IDLE SHALL occur when Enable_In=0.
REQ-016 ARB SHALL latch Mode_In, choose a channel into Select_Out, clear the burst counter and go to XFER, taking 1 cycle.
REQ-017 ARB channel choice SHALL be:
- 00: 0.
- 01: 1.
- 10: inverse of the last completed burst's channel.
- 11: the channel with Ready high; if both are high, the inverse of the last channel; if neither, remain in ARB.
REQ-018 Mode_In changes SHALL take effect only at the next ARB.
REQ-019 There SHALL be a single holding register (data plus hold_valid).
REQ-020 Valid_k_Out SHALL equal hold_valid AND (Select_Out==k).
REQ-021 Data_k_Out SHALL equal the holding data when Select_Out==k, else 0.
REQ-022 Output transfer SHALL be Valid_k_Out AND Ready_k_In, and SHALL clear hold_valid unless a load occurs in the same cycle.
REQ-023 Ready_Out SHALL equal (state==XFER) AND Enable_In AND (NOT hold_valid OR Ready_sel_In), where Ready_sel_In is the Ready of the selected channel.
REQ-024 Acceptance (Valid_In AND Ready_Out) SHALL load the holding register and increment the burst counter.
REQ-025 Simultaneous load and unload SHALL leave hold_valid=1 with the new word, giving full throughput of 1 word/cycle.
REQ-026 Latency SHALL be: a word accepted on edge N appears on Valid_k_Out/Data_k_Out after edge N, with 1 cycle of latency.
REQ-027 When the counter reaches BURST_LEN on an acceptance, the state SHALL go XFER->DRAIN, and Ready_Out SHALL be 0 in DRAIN.
REQ-028 DRAIN->ARB SHALL occur on the cycle hold_valid is 0 (or is cleared by a transfer) in that cycle, with Burst_Done_Out=1 for exactly that cycle, and the last channel updated to Select_Out.
REQ-029 Enable_In=0 in XFER SHALL drop Ready_Out immediately and pause the burst (counter retained); the holding register SHALL still drain, and the burst SHALL resume on re-enable.
REQ-030 Enable_In=0 in DRAIN SHALL NOT block completion; the subsequent ARB then returns to IDLE.
REQ-031 Select_Out SHALL be stable from ARB exit to DRAIN exit; no word SHALL ever appear on the non-selected channel.
REQ-032 Downstream backpressure SHALL hold Data_k_Out/Valid_k_Out stable until transfer.
REQ-033 Words SHALL be neither dropped nor duplicated.

Reset
REQ-034 On Reset_n_In=0, immediately and independent of Clock_In: state=IDLE, hold_valid=0, counter=0, Select_Out=0, last channel=1, all outputs 0, Ready_Out=0.
REQ-035 Reset asserted mid-burst SHALL discard the held word and the partial burst.
REQ-036 After reset release, the first round-robin burst SHALL go to ch0.

Verification
REQ-037 Mode=10, BURST_LEN=4, both Ready=1, Valid_In constant, 8 words 0x01..0x08 -> 0x01..0x04 on ch0, 0x05..0x08 on ch1, Burst_Done_Out pulses twice, Valid_1_Out never high during ch0 burst.
REQ-038 Mode=00, Ready_0_In=0 for 5 cycles after the first accept -> Ready_Out=0, Data_0_Out holds 0x01 stable, no word lost after Ready_0_In=1.
REQ-039 Mode=11, Ready_0_In=0, Ready_1_In=1 at ARB -> Select_Out=1; both Ready=0 -> block stays in ARB with Ready_Out=0.
REQ-040 Enable_In=0 after 2 of 4 words -> Ready_Out=0 next cycle, held word drains; re-enable -> exactly 2 more words accepted before Burst_Done_Out.
REQ-041 Reset_n_In pulsed low mid-burst, asynchronous to the clock -> all outputs 0 immediately, next Mode=10 burst on ch0.
REQ-042 Mode_In changed 00->01 mid-burst -> current burst completes on ch0, next burst on ch1.
